// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM encoding, common
// device command bytes and small helpers.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        DATA      = 3'd3,
        PARITY    = 3'd4,
        STOP      = 3'd5,
        ACK       = 3'd6,
        WAIT_IDLE = 3'd7
    } state_t;

    localparam logic [7:0] SET_LEDS = 8'hED;
    localparam logic [7:0] ECHO     = 8'hEE;
    localparam logic [7:0] ENABLE   = 8'hF4;
    localparam logic [7:0] RESET    = 8'hFF;

    // PS/2 frames carry odd parity: data bits plus parity hold an odd count of ones.
    function automatic logic odd_parity(input logic [7:0] value);
        return ~^value;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one raw PS/2 line, plus a one-cycle falling-edge
// strobe derived from the synchronised level.
module ps2_line_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic line,
    output logic level,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Open-drain lines idle high; resetting to 1 avoids a false edge on release.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make the three flops shift as a chain on one edge.
            meta_q <= line;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter driving open-drain clock/data enables.
// Define PS2_TX_TIMEOUT_EN to add a device-response watchdog (TIMEOUT_MS).
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int INHIBIT_US   = 100,
    parameter int SETUP_CYCLES = 50,
    parameter int TIMEOUT_MS   = 15
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe,
    output logic       o_done,
    output logic       o_error
);

    localparam int INHIBIT_CYCLES = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
    localparam int PHASE_MAX      = max_int(INHIBIT_CYCLES, SETUP_CYCLES);
    localparam int PHASE_W        = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam logic [PHASE_W-1:0] INHIBIT_LAST = PHASE_W'(INHIBIT_CYCLES - 1);
    localparam logic [PHASE_W-1:0] SETUP_LAST   = PHASE_W'(SETUP_CYCLES - 1);

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               parity_q, parity_d;
    logic               data_oe_q, data_oe_d;
    logic               ack_q, ack_d;
    logic               done_pulse;
    logic               error_pulse;
    logic               wd_expired;

    logic ps2_clk_s;
    logic ps2_clk_fall;
    logic ps2_data_s;
    logic data_fall_unused;

    ps2_line_sync u_clk_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .line  (i_ps2_clk),
        .level (ps2_clk_s),
        .fall  (ps2_clk_fall)
    );

    ps2_line_sync u_data_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .line  (i_ps2_data),
        .level (ps2_data_s),
        .fall  (data_fall_unused)
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1000 * TIMEOUT_MS;
    localparam int WD_W           = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q;
    logic            wd_active;

    // Armed only while the device owns the clock; each device clock edge restarts it.
    assign wd_active  = state_q inside {DATA, PARITY, STOP, ACK, WAIT_IDLE};
    assign wd_expired = wd_active && (wd_q == WD_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wd_q <= '0;
        end else if (!wd_active || ps2_clk_fall || wd_expired) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + WD_W'(1);
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            data_oe_q <= data_oe_d;
            ack_q     <= ack_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        data_oe_d   = data_oe_q;
        ack_d       = ack_q;
        done_pulse  = 1'b0;
        error_pulse = 1'b0;

        unique case (state_q)
            IDLE: begin
                data_oe_d = 1'b0;
                if (i_valid) begin
                    shift_d  = i_data;
                    parity_d = odd_parity(i_data);
                    phase_d  = '0;
                    bit_d    = '0;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (phase_q == INHIBIT_LAST) begin
                    phase_d   = '0;
                    data_oe_d = 1'b1;       // start bit goes low together with REQ
                    state_d   = REQ;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            REQ: begin
                if (phase_q == SETUP_LAST) begin
                    phase_d = '0;
                    state_d = DATA;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            DATA: begin
                if (ps2_clk_fall) begin
                    data_oe_d = ~shift_q[bit_q];
                    bit_d     = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (ps2_clk_fall) begin
                    data_oe_d = ~parity_q;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (ps2_clk_fall) begin
                    data_oe_d = 1'b0;
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (ps2_clk_fall) begin
                    ack_d   = ~ps2_data_s;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (ps2_clk_s && ps2_data_s) begin
                    done_pulse  = ack_q;
                    error_pulse = ~ack_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog expiry overrides any completion in the same cycle.
        if (wd_expired) begin
            state_d     = IDLE;
            data_oe_d   = 1'b0;
            done_pulse  = 1'b0;
            error_pulse = 1'b1;
        end
    end

    assign o_ready       = (state_q == IDLE) && !i_rst;
    assign o_busy        = (state_q != IDLE);
    assign o_ps2_clk_oe  = (state_q == INHIBIT) || (state_q == REQ);
    assign o_ps2_data_oe = data_oe_q;
    assign o_done        = done_pulse;
    assign o_error       = error_pulse;

endmodule
